is_uart_rx: RTL and testbench

UART receive deserializer that sits directly downstream of the RX line synchronizer. It takes the already-synchronized serial line, detects start bits using 16x oversampling, and samples each bit at mid-bit. It assembles LSB-first data words and delivers them to the system side through a valid/ready holding register, with frame-error and overrun reporting.

---
 rtl/is_uart_pkg.sv | 21 ++
 rtl/is_uart_baud_gen.sv | 36 +++
 rtl/is_uart_rx.sv | 175 +++++++++++++++++
 tb/tb_is_uart_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/is_uart_pkg.sv
// rtl/is_uart_pkg.sv - shared types and constants for the is_uart blocks
// Purpose: receiver state encoding, oversampling ratio and the baud divider helper.
package is_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Clocks per oversample tick, floored.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/is_uart_baud_gen.sv
// rtl/is_uart_baud_gen.sv - 16x oversampling tick generator
// Purpose: one-cycle tick every DIV clocks; restart_i re-phases the count to 0.
// Ports:
//   clk_i     - system clock
//   rst_i     - asynchronous active-high reset
//   restart_i - synchronous restart, counter is 0 after the edge
//   tick_o    - one-cycle tick pulse
module is_uart_baud_gen #(
  parameter int DIV = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick_o = w_wrap;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (restart_i || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/is_uart_rx.sv
// rtl/is_uart_rx.sv - UART receive deserializer with valid/ready holding register
// Purpose: detects start bits with 16x oversampling, samples mid-bit, assembles
//   LSB-first words and presents them with frame/parity error and overrun flags.
// Optional feature macro: IS_UART_PARITY_EN (adds one parity bit per frame).
// Ports:
//   clk_i, rst_i       - clock, asynchronous active-high reset
//   uart_rxd_r_i       - synchronized RX line, idle high
//   rx_data_o          - held word, valid while rx_valid_o
//   rx_valid_o         - word available
//   rx_ready_i         - consumer accepts the word
//   frame_err_o        - stop bit was 0 for the held word
//   parity_err_o       - parity mismatch for the held word
//   overrun_o          - one-cycle pulse when a word was dropped
//   busy_o             - FSM not in IDLE
module is_uart_rx
  import is_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rxd_r_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int         DIV      = calc_div(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("is_uart_rx: CLK_FREQ/(BAUD_RATE*16) must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
    $error("is_uart_rx: DATA_BITS must be 5..8");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
    $error("is_uart_rx: PARITY_ODD must be 0 or 1");
  end

  rx_state_t            r_state, w_next;
  logic                 w_tick, w_restart, w_load, w_accept;
  logic                 w_mid, w_end;
  logic [3:0]           r_sample;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_ferr, r_overrun;

  is_uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (w_restart),
    .tick_o    (w_tick)
  );

  // Start bit is checked at its middle; every later bit at the end of a 16-tick window.
  assign w_mid = w_tick && (r_sample == 4'd7);
  assign w_end = w_tick && (r_sample == 4'd15);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (!uart_rxd_r_i) w_next = START;
      START:  if (w_mid) w_next = uart_rxd_r_i ? IDLE : DATA;
      DATA: begin
        if (w_end && (r_bit == LAST_BIT)) begin
`ifdef IS_UART_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef IS_UART_PARITY_EN
      PARITY: if (w_end) w_next = STOP;
`endif
      STOP:   if (w_end) w_next = uart_rxd_r_i ? IDLE : BREAK;
      BREAK:  if (uart_rxd_r_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (r_state != IDLE);
    w_restart = (r_state == IDLE) && !uart_rxd_r_i;
    w_load    = (r_state == STOP) && w_end;
  end

  // Sample counter free-runs on ticks; it is cleared at the falling edge and
  // again after the start check so data windows start at count 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sample <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
    end else begin
      if (w_restart) begin
        r_sample <= '0;
      end else if (w_tick) begin
        if (r_state == START && r_sample == 4'd7) begin
          r_sample <= '0;
        end else begin
          r_sample <= r_sample + 4'd1;
        end
      end
      if (r_state == DATA && w_end) begin
        r_shift <= {uart_rxd_r_i, r_shift[DATA_BITS-1:1]};
        r_bit   <= (r_bit == LAST_BIT) ? 3'd0 : r_bit + 3'd1;
      end
    end
  end

  // A load is taken when the register is empty or being emptied this cycle.
  assign w_accept = w_load && (!r_valid || rx_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_load && !w_accept;
      if (w_accept) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_ferr  <= !uart_rxd_r_i;
      end else if (r_valid && rx_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef IS_UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic r_par_bit, r_perr, w_perr;

  assign w_perr = ((^r_shift) ^ r_par_bit) != PAR_ODD;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (r_state == PARITY && w_end) r_par_bit <= uart_rxd_r_i;
      if (w_accept) r_perr <= w_perr;
    end
  end

  assign parity_err_o = r_perr;
`else
  assign parity_err_o = 1'b0;
`endif

  assign rx_data_o   = r_data;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_ferr;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_is_uart_rx.sv
// tb/tb_is_uart_rx.sv - scoreboard testbench for is_uart_rx
module tb_is_uart_rx;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD_RATE  = 115200;
  localparam int DATA_BITS  = 8;
  localparam int PARITY_ODD = 0;
  localparam int DIV        = 27;
  localparam int BIT_CLKS   = 432;
`ifdef IS_UART_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  // Edge driven at a negedge is seen at the next posedge (+1); the stop sample
  // is tick 24+16*(bits before stop) and the word is visible after that edge.
  localparam int LAT = 1 + DIV * (24 + 16 * (DATA_BITS + NPAR));

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         t0;
  } exp_t;

  exp_t sb[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int ovr_cyc = 0;
  int t_edge = 0;
  int busy_cnt;

  is_uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_BITS  (DATA_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .uart_rxd_r_i (rxd),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (ready),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err),
    .overrun_o    (overrun),
    .busy_o       (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ((($countones(d) % 2) == 1) != (PARITY_ODD != 0));
  endfunction

  task automatic hold_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input logic expect_word);
    exp_t e;
    @(negedge clk);
    t_edge = cyc;
    if (expect_word) begin
      e.data = d;
      e.ferr = !stop_b;
      e.perr = (NPAR == 1) && ((($countones(d) + int'(par_b)) % 2) != PARITY_ODD);
      e.t0   = cyc;
      sb.push_back(e);
    end
    hold_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) hold_bit(d[i]);
    if (NPAR == 1) hold_bit(par_b);
    hold_bit(stop_b);
  endtask

  task automatic release_word();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("released", rx_valid, 0);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t       e;
        logic       prev_valid;
        logic [7:0] held;
        prev_valid = 1'b0;
        held = 8'h00;
        forever begin
          @(negedge clk);
          if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
          end
          if (rx_valid && !prev_valid) begin
            check("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("word_data", rx_data, e.data);
              check("word_ferr", frame_err, e.ferr);
              check("word_perr", parity_err, e.perr);
              check("word_latency", cyc - e.t0, LAT);
              held = e.data;
            end
          end else if (rx_valid && prev_valid && rx_data !== held) begin
            check("data_stable", rx_data, held);
          end
          prev_valid = rx_valid;
        end
      end
    join_none

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy", busy, 0);

    // Clean frame held until the consumer accepts it
    send_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b1);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("a5_valid_held", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_ferr", frame_err, 0);
    check("a5_busy", busy, 0);
    release_word();

    // 100-clock glitch: false start rejected at the 8th tick
    @(negedge clk);
    rxd = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 99) rxd = 1'b1;
      if (busy) busy_cnt++;
    end
    check("glitch_busy_clks", busy_cnt, 8 * DIV);
    check("glitch_no_valid", rx_valid, 0);

    // Stop bit 0 followed by a long break
    send_frame(8'h3C, 1'b0, good_par(8'h3C), 1'b1);
    repeat (2000) @(negedge clk);
    check("brk_busy", busy, 1);
    check("brk_valid", rx_valid, 1);
    check("brk_data", rx_data, 8'h3C);
    check("brk_ferr", frame_err, 1);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("brk_end_busy", busy, 0);
    release_word();

    // Back-to-back with no consumer: second word dropped
    send_frame(8'h11, 1'b1, good_par(8'h11), 1'b1);
    send_frame(8'h22, 1'b1, good_par(8'h22), 1'b0);
    rxd = 1'b1;
    repeat (50) @(negedge clk);
    check("ovr_count", ovr_cnt, 1);
    check("ovr_time", ovr_cyc - t_edge, LAT);
    check("ovr_held_data", rx_data, 8'h11);
    check("ovr_held_valid", rx_valid, 1);

    // Reset in the middle of data bit 4 of 0xFF, with 0x11 still held
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ferr", frame_err, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (4 * BIT_CLKS) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", rx_valid, 0);
    send_frame(8'h5A, 1'b1, good_par(8'h5A), 1'b1);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("5a_valid", rx_valid, 1);
    check("5a_data", rx_data, 8'h5A);
    release_word();

`ifdef IS_UART_PARITY_EN
    // Even parity, 0x07 has three ones: parity bit 0 is wrong, 1 is right
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("par_bad", parity_err, 1);
    release_word();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("par_good", parity_err, 0);
    release_word();
`endif

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("ovr_total", ovr_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
